// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, the BCD nine digit and the overflow bound helper.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    FINISH  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // Largest value representable with the given number of BCD digits.
  function automatic logic [63:0] bcd_max(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with sign, overflow saturation and a latched display-mode flag.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     binary_in,
  input  logic                  mode_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  ovf,
  output logic                  mode_out
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(DATA_W);
  localparam logic [63:0] MAX_VAL = bcd_max(DIGITS);
  localparam logic [BCD_W-1:0] BCD_SAT = {DIGITS{BCD_NINE}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [BCD_W-1:0]   acc_adj;
  logic               neg_pend_q, neg_pend_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               mode_pend_q, mode_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;

  logic               in_neg;
  logic [DATA_W-1:0]  mag;

  assign in_neg = SIGNED && binary_in[DATA_W-1];
  // Magnitude is taken as unsigned, so the most negative input stays large and overflows.
  assign mag    = in_neg ? (~binary_in + DATA_W'(1)) : binary_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    neg_pend_d  = neg_pend_q;
    ovf_pend_d  = ovf_pend_q;
    mode_pend_d = mode_pend_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    mode_d      = mode_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_pend_d  = in_neg;
          mode_pend_d = mode_in;
          if (64'(mag) > MAX_VAL) begin
            ovf_pend_d = 1'b1;
            state_d    = FINISH;
          end else begin
            ovf_pend_d = 1'b0;
            shift_d    = mag;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = CONVERT;
          end
        end
      end
      CONVERT: begin
        {acc_d, shift_d} = {acc_adj, shift_q} << 1;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        bcd_d   = ovf_pend_q ? BCD_SAT : acc_q;
        neg_d   = neg_pend_q;
        ovf_d   = ovf_pend_q;
        mode_d  = mode_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      neg_pend_q  <= 1'b0;
      ovf_pend_q  <= 1'b0;
      mode_pend_q <= 1'b0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      neg_pend_q  <= neg_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      mode_pend_q <= mode_pend_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
    end
  end

  // Datapath registers carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    acc_q   <= acc_d;
  end

  assign busy     = (state_q == CONVERT);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign neg      = neg_q;
  assign ovf      = ovf_q;
  assign mode_out = mode_q;

endmodule
